mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch port and the load/store data port of the RV32I core. Grants one transaction at a time and tracks it through a fixed memory latency. Returns read data to the owning requester; on the data side it also generates byte enables and sign/zero-extends loads from funct3. Sits between the fetch/memory stages and the memory macro; the stall logic reads its grant/valid outputs.

## Interface
- ADDR_WIDTH, 32, byte address width
- MEM_LATENCY, 1, cycles from accepted memory request to mem_rdata valid; legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address, word-aligned
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  instruction word
- d_req  in  1  data request; held, with its fields stable, until d_gnt or d_err
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  byte address
- d_wdata  in  32  store data, LSB-justified
- d_funct3  in  3  access size/sign (RV32I load/store funct3)
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete, 1-cycle pulse
- d_rdata  out  32  extended load data; 0 on store completion
- d_err  out  1  misaligned access rejected, 1-cycle pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0] forced 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word

## Operation
- FSM states: IDLE, WAIT.
- IDLE: arbitrate among the valid requests. If only one requester is active, it wins. If both are active, the winner is the requester that did not win the last grant. The priority pointer resets to "data wins".
- The winner's gnt and mem_en/mem_we/mem_addr/mem_be/mem_wdata are driven combinationally in the same cycle.
- On a grant, latch owner, funct3 and addr[1:0], load the counter with MEM_LATENCY, and go to WAIT.
- WAIT: decrement the counter each cycle. No grants are issued.
- When the counter reaches 1, raise the owner's rvalid. The response data is taken from mem_rdata that cycle. Return to IDLE next cycle.
- Byte enables:
  - SB: 0001 << addr[1:0]
  - SH: 0011 << {addr[1],1'b0}
  - SW: 1111
  - Store data is replicated across lanes: SB {4{b}}, SH {2{h}}.
- Load extract: select the lane by latched addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Misaligned access: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]≠0.
  - In IDLE it pulses d_err instead of d_gnt, with no mem_en.
  - It does not consume an arbitration slot; if fetch is also active, fetch is granted the same cycle.
- Unlisted funct3 (011, 110, 111): treated as misaligned, so d_err.
- Fetch address: bits [1:0] are ignored.

## Timing
- Reset values: all gnt/rvalid/err = 0, if_rdata = d_rdata = 0, mem_en = mem_we = 0, mem_be = 0, state IDLE, counter 0, pointer = data.
- Latency: grant at cycle T, rvalid at cycle T+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY+1 cycles. No grant is issued in the rvalid cycle.
- rst asserted in WAIT: the transaction is abandoned and no rvalid is produced. From the next cycle the block is in IDLE with reset values.
- A requester that deasserts req before its gnt: legal; it is simply not granted.
- req held high after gnt: treated as a new request in the next IDLE cycle.
- Counter width: 4 bits.

## Structure
- Package mem_pkg:
  - funct3 localparams LB/LH/LW/LBU/LHU/SB/SH/SW
  - owner_t enum {OWN_IF, OWN_D}
  - state_t enum {IDLE, WAIT}
- Sub-module mem_lane_align (combinational): (funct3, addr[1:0], wdata, rdata) → (be, wdata_rep, rdata_ext, misaligned). Instantiated once in mem_arbiter.

## Test plan
- Reset: assert rst 3 cycles with both reqs high → all outputs 0. First IDLE cycle after reset, both requesting → d_gnt=1, if_gnt=0.
- Contention, MEM_LATENCY=2, both requesting continuously → grants alternate D, IF, D, IF, one every 3 cycles. rvalid appears 2 cycles after each grant to the correct owner.
- LB at addr 0x103, mem_rdata=0x80FF_FF00 → mem_be=4'b1000, d_rdata=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x202, d_wdata=0x1234_ABCD → mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1, d_rvalid pulse with d_rdata=0.
- SW at 0x101 with if_req also high → d_err pulse, if_gnt same cycle, no mem_we.
- rst asserted in the cycle after a fetch grant (MEM_LATENCY=3) → no if_rvalid is ever produced. After rst drops, the next grant is issued in the first IDLE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg                                                                    |
// | Shared funct3 encodings, owner and state types for the memory arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int CNT_W = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lane_align                                                             |
// | Byte-enable generation, store lane replication and load extraction.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        w_byte     = rdata[{addr_lo, 3'b000} +: 8];
        w_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        // funct3[2] distinguishes the zero-extending load variants
        case (funct3)
            LB, LBU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            LH, LHU: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            LW: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Fetch/data arbiter for the unified single-ported memory with fixed latency.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] c_word_mask = ~ADDR_WIDTH'(3);
    localparam logic [CNT_W-1:0]      c_latency   = CNT_W'(MEM_LATENCY);

    state_t           r_state,  w_state_nx;
    owner_t           r_owner,  w_owner_nx;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [2:0]       r_f3,     w_f3_nx;
    logic [1:0]       r_lo,     w_lo_nx;
    logic             r_we,     w_we_nx;
    logic             r_prio_d, w_prio_d_nx;

    logic [2:0]  w_lane_f3;
    logic [1:0]  w_lane_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;
    logic        w_misaligned;
    logic        w_d_ok;

    // One aligner serves both phases: live request fields in IDLE, latched ones in WAIT
    assign w_lane_f3 = (r_state == WAIT) ? r_f3 : d_funct3;
    assign w_lane_lo = (r_state == WAIT) ? r_lo : d_addr[1:0];
    assign w_d_ok    = d_req && !w_misaligned;

    mem_lane_align u_lane_align (
        .funct3     (w_lane_f3),
        .addr_lo    (w_lane_lo),
        .wdata      (d_wdata),
        .rdata      (mem_rdata),
        .be         (w_be),
        .wdata_rep  (w_wdata_rep),
        .rdata_ext  (w_rdata_ext),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_IF;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_lo     <= '0;
            r_we     <= 1'b0;
            r_prio_d <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_cnt    <= w_cnt_nx;
            r_f3     <= w_f3_nx;
            r_lo     <= w_lo_nx;
            r_we     <= w_we_nx;
            r_prio_d <= w_prio_d_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_cnt_nx    = r_cnt;
        w_f3_nx     = r_f3;
        w_lo_nx     = r_lo;
        w_we_nx     = r_we;
        w_prio_d_nx = r_prio_d;
        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = 4'b0000;
        mem_wdata   = '0;

        // Outputs are held quiet for the whole reset cycle, including an abandoned WAIT
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    d_err = d_req && w_misaligned;
                    if (w_d_ok && (!if_req || r_prio_d)) begin
                        d_gnt       = 1'b1;
                        mem_en      = 1'b1;
                        mem_we      = d_we;
                        mem_addr    = d_addr & c_word_mask;
                        mem_be      = w_be;
                        mem_wdata   = d_we ? w_wdata_rep : '0;
                        w_owner_nx  = OWN_D;
                        w_we_nx     = d_we;
                        w_f3_nx     = d_funct3;
                        w_lo_nx     = d_addr[1:0];
                        w_prio_d_nx = 1'b0;
                        w_cnt_nx    = c_latency;
                        w_state_nx  = WAIT;
                    end else if (if_req) begin
                        if_gnt      = 1'b1;
                        mem_en      = 1'b1;
                        mem_addr    = if_addr & c_word_mask;
                        mem_be      = 4'b1111;
                        w_owner_nx  = OWN_IF;
                        w_we_nx     = 1'b0;
                        w_f3_nx     = LW;
                        w_lo_nx     = 2'b00;
                        w_prio_d_nx = 1'b1;
                        w_cnt_nx    = c_latency;
                        w_state_nx  = WAIT;
                    end
                end
                WAIT: begin
                    w_cnt_nx = r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = IDLE;
                        if (r_owner == OWN_IF) begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end else begin
                            d_rvalid = 1'b1;
                            d_rdata  = r_we ? '0 : w_rdata_ext;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Directed vector bench for mem_arbiter (latency 2, plus a latency-3 copy).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_funct3;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, d_err_3, mem_en_3, mem_we_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3;
    logic [3:0]  mem_be_3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(1'b0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3), .d_err(d_err_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_be(mem_be_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] drdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          we    f3       addr          wdata         rdata         err   be       maddr         mwdata        drdata
        vecs[0]  = '{1'b0, LB,     32'h0000_0103, 32'hFFFF_FFFF, 32'h80FF_FF00, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, LBU,    32'h0000_0103, 32'hFFFF_FFFF, 32'h80FF_FF00, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080};
        vecs[2]  = '{1'b1, SH,     32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0};
        vecs[3]  = '{1'b0, LH,     32'h0000_0002, 32'h0,         32'h8001_1234, 1'b0, 4'b1100, 32'h0000_0000, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{1'b0, LHU,    32'h0000_0000, 32'h0,         32'h8001_F234, 1'b0, 4'b0011, 32'h0000_0000, 32'h0,        32'h0000_F234};
        vecs[5]  = '{1'b0, LW,     32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, SB,     32'h0000_0105, 32'h0000_00A5, 32'h0,         1'b0, 4'b0010, 32'h0000_0104, 32'hA5A5_A5A5, 32'h0};
        vecs[7]  = '{1'b1, SW,     32'h0000_0108, 32'h1122_3344, 32'h0,         1'b0, 4'b1111, 32'h0000_0108, 32'h1122_3344, 32'h0};
        vecs[8]  = '{1'b0, LH,     32'h0000_0001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[9]  = '{1'b0, LW,     32'h0000_0002, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[11] = '{1'b0, LB,     32'h0000_0002, 32'h0,         32'h0012_7F00, 1'b0, 4'b0100, 32'h0000_0000, 32'h0,        32'h0000_0012};

        // Reset with both requesters active
        rst = 1'b1; rst3 = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_if_gnt", if_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
            chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_d_err", d_err, 0);         chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);       chk("rst_mem_be", mem_be, 0);
            chk("rst_if_rdata", if_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
        end
        rst = 1'b0; rst3 = 1'b0;

        // Continuous contention: D, IF, D, IF, one grant every 3 cycles
        for (int c = 0; c < 12; c++) begin
            automatic bit d_own = ((c / 3) % 2) == 0;
            automatic bit ph0   = (c % 3) == 0;
            automatic bit ph2   = (c % 3) == 2;
            #1;
            chk("cont_d_gnt", d_gnt, ph0 && d_own);
            chk("cont_if_gnt", if_gnt, ph0 && !d_own);
            chk("cont_d_rvalid", d_rvalid, ph2 && d_own);
            chk("cont_if_rvalid", if_rvalid, ph2 && !d_own);
            if (ph2 && d_own)  chk("cont_d_rdata", d_rdata, 32'hCAFE_0001);
            if (ph2 && !d_own) chk("cont_if_rdata", if_rdata, 32'hCAFE_0001);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;

        // Single data transactions from the vector table
        for (int i = 0; i < 12; i++) begin
            d_req = 1'b1; d_we = vecs[i].we; d_funct3 = vecs[i].f3;
            d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
            #1;
            chk("vec_d_gnt", d_gnt, !vecs[i].err);
            chk("vec_d_err", d_err, vecs[i].err);
            chk("vec_mem_en", mem_en, !vecs[i].err);
            chk("vec_mem_we", mem_we, vecs[i].we && !vecs[i].err);
            if (!vecs[i].err) begin
                chk("vec_mem_addr", mem_addr, vecs[i].maddr);
                chk("vec_mem_be", mem_be, vecs[i].be);
                if (vecs[i].we) chk("vec_mem_wdata", mem_wdata, vecs[i].mwdata);
            end
            tick();
            d_req = 1'b0; d_funct3 = LW; d_addr = 32'h0;
            if (!vecs[i].err) begin
                #1;
                chk("vec_wait_rvalid", d_rvalid, 0);
                tick();
                mem_rdata = vecs[i].rdata;
                #1;
                chk("vec_d_rvalid", d_rvalid, 1);
                chk("vec_d_rdata", d_rdata, vecs[i].drdata);
                chk("vec_if_rvalid", if_rvalid, 0);
                tick();
            end else begin
                #1;
                chk("vec_err_pulse", d_err, 0);
            end
        end

        // Misaligned SW alongside a fetch: error and fetch grant in the same cycle
        d_req = 1'b1; d_we = 1'b1; d_funct3 = SW; d_addr = 32'h0000_0101; d_wdata = 32'h7777_7777;
        if_req = 1'b1; if_addr = 32'h0000_0207;
        #1;
        chk("mis_d_err", d_err, 1);
        chk("mis_d_gnt", d_gnt, 0);
        chk("mis_if_gnt", if_gnt, 1);
        chk("mis_mem_we", mem_we, 0);
        chk("mis_mem_addr", mem_addr, 32'h0000_0204);
        tick();
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        #1;
        chk("mis_wait_rvalid", if_rvalid, 0);
        tick();
        mem_rdata = 32'h0000_0013;
        #1;
        chk("mis_if_rvalid", if_rvalid, 1);
        chk("mis_if_rdata", if_rdata, 32'h0000_0013);
        chk("mis_d_rvalid", d_rvalid, 0);
        tick();

        // Latency-3 copy: reset during WAIT abandons the fetch
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        chk("abort_if_gnt", if_gnt_3, 1);
        tick();
        rst3 = 1'b1; if_req = 1'b0;
        #1;
        chk("abort_rst_rvalid", if_rvalid_3, 0);
        tick();
        rst3 = 1'b0; if_req = 1'b1;
        #1;
        chk("abort_regnt", if_gnt_3, 1);
        chk("abort_regnt_rvalid", if_rvalid_3, 0);
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("abort_rvalid", if_rvalid_3, (k == 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
